alu_flag_register: RTL and testbench

Architectural status register sitting directly downstream of the ALU flag-control stage: captures the per-operation Carry/Neg/Equal flags, holds them across cycles, and evaluates branch condition codes against them. Also provides a small LIFO save/restore stack so the sequencer can preserve flags across subroutine/interrupt entry. Feeds the branch/sequencer logic.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/flag_stack.sv | 79 +++++++
 rtl/alu_flag_register.sv | 88 ++++++++
 tb/tb_alu_flag_register.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU status definitions: condition codes, ALU selector values, flag bundle
// and the condition-code evaluator used by the flag register.
package alu_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_CS     = 3'd5,
    COND_CC     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;

  typedef struct packed {
    logic carry;
    logic neg;
    logic equal;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '{carry: 1'b0, neg: 1'b0, equal: 1'b0};

  function automatic logic cond_eval(input cond_e cs, input flags_t f);
    logic res;
    res = 1'b0;
    case (cs)
      COND_ALWAYS: res = 1'b1;
      COND_EQ:     res = f.equal;
      COND_NE:     res = ~f.equal;
      COND_LT:     res = f.neg;
      COND_GE:     res = ~f.neg;
      COND_CS:     res = f.carry;
      COND_CC:     res = ~f.carry;
      COND_NEVER:  res = 1'b0;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag bundles. Resolves push/pop legality itself and reports a
// sticky error for overflow, underflow, or a simultaneous push and pop.
module flag_stack
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  input  flags_t        push_data,
  output flags_t        pop_data,
  output logic          pop_ok,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t          mem [2**AW];
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic            do_push;
  logic            do_pop;
  logic            err_set;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_idx = AW'(count_q);
  assign rd_idx = AW'(count_q - CW'(1));

  // A simultaneous push and pop is ambiguous, so neither side is performed.
  always_comb begin
    do_push = push & ~pop & ~full;
    do_pop  = pop & ~push & ~empty;
    err_set = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CW'(1);
    end else if (do_pop) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Error set has priority over clear so no fault is lost in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  assign pop_data = mem[rd_idx];
  assign pop_ok   = do_pop;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: rtl/alu_flag_register.sv
// Architectural Carry/Neg/Equal register with save/restore stack and branch
// condition evaluation. Define ALU_FLAG_BYPASS_EN to evaluate CondTrue on next-state flags.
module alu_flag_register
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         FlagWe,
  input  logic [3:0]                   Selector,
  input  logic                         CarryIn,
  input  logic                         NegIn,
  input  logic                         EqualIn,
  input  logic                         Push,
  input  logic                         Pop,
  input  logic                         ErrClr,
  input  logic [2:0]                   CondSel,
  output logic                         CondTrue,
  output logic                         CarryOut,
  output logic                         NegOut,
  output logic                         EqualOut,
  output logic [$clog2(DEPTH+1)-1:0]   StackCount,
  output logic                         StackFull,
  output logic                         StackEmpty,
  output logic                         StackErr
);

  flags_t flags_q;
  flags_t flags_next;
  flags_t pop_data;
  flags_t cond_src;
  logic   pop_ok;

  // The stack always captures the pre-write register value, so a push in the
  // same cycle as a flag write saves the old flags.
  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (Push),
    .pop       (Pop),
    .err_clr   (ErrClr),
    .push_data (flags_q),
    .pop_data  (pop_data),
    .pop_ok    (pop_ok),
    .count     (StackCount),
    .full      (StackFull),
    .empty     (StackEmpty),
    .err       (StackErr)
  );

  // A successful pop overrides any flag write in the same cycle.
  always_comb begin
    flags_next = flags_q;
    if (pop_ok) begin
      flags_next = pop_data;
    end else if (FlagWe) begin
      if (Selector == SEL_ADD) begin
        flags_next.carry = CarryIn;
      end else if (Selector == SEL_SUB) begin
        flags_next.neg   = NegIn;
        flags_next.equal = EqualIn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_CLEAR;
    end else begin
      flags_q <= flags_next;
    end
  end

`ifdef ALU_FLAG_BYPASS_EN
  assign cond_src = flags_next;
`else
  assign cond_src = flags_q;
`endif

  assign CondTrue = cond_eval(cond_e'(CondSel), cond_src);
  assign CarryOut = flags_q.carry;
  assign NegOut   = flags_q.neg;
  assign EqualOut = flags_q.equal;

endmodule

// File: tb/tb_alu_flag_register.sv
// Randomized bench for alu_flag_register against a queue-based reference model
// of the flags, save stack and sticky error.
module tb_alu_flag_register;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          FlagWe = 1'b0;
  logic [3:0]    Selector = '0;
  logic          CarryIn = 1'b0, NegIn = 1'b0, EqualIn = 1'b0;
  logic          Push = 1'b0, Pop = 1'b0, ErrClr = 1'b0;
  logic [2:0]    CondSel = '0;
  logic          CondTrue, CarryOut, NegOut, EqualOut;
  logic [CW-1:0] StackCount;
  logic          StackFull, StackEmpty, StackErr;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_c, m_n, m_e, m_err;
  bit [2:0] m_stack[$];

  alu_flag_register #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .FlagWe(FlagWe), .Selector(Selector),
    .CarryIn(CarryIn), .NegIn(NegIn), .EqualIn(EqualIn),
    .Push(Push), .Pop(Pop), .ErrClr(ErrClr), .CondSel(CondSel),
    .CondTrue(CondTrue), .CarryOut(CarryOut), .NegOut(NegOut), .EqualOut(EqualOut),
    .StackCount(StackCount), .StackFull(StackFull), .StackEmpty(StackEmpty),
    .StackErr(StackErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ref(input logic [2:0] cs, input bit c, input bit n, input bit e);
    bit [7:0] truth;
    truth = {1'b0, !c, c, !n, n, !e, e, 1'b1};
    return truth[cs];
  endfunction

  task automatic check_regs();
    check("carry_out",   8'(CarryOut),   8'(m_c));
    check("neg_out",     8'(NegOut),     8'(m_n));
    check("equal_out",   8'(EqualOut),   8'(m_e));
    check("stack_count", 8'(StackCount), 8'(m_stack.size()));
    check("stack_full",  8'(StackFull),  8'(m_stack.size() == DEPTH));
    check("stack_empty", 8'(StackEmpty), 8'(m_stack.size() == 0));
    check("stack_err",   8'(StackErr),   8'(m_err));
  endtask

  task automatic model_reset();
    m_c = 0; m_n = 0; m_e = 0; m_err = 0;
    m_stack.delete();
  endtask

  // One clock: check registered state, drive inputs, check CondTrue, advance model.
  task automatic cycle(input bit we, input logic [3:0] sel, input bit c, input bit n,
                       input bit e, input bit push, input bit pop, input bit clr,
                       input logic [2:0] cs);
    bit n_c, n_n, n_e, n_err, new_err, push_take, pop_take;
    bit [2:0] top;
    @(negedge clk);
    check_regs();
    FlagWe = we; Selector = sel; CarryIn = c; NegIn = n; EqualIn = e;
    Push = push; Pop = pop; ErrClr = clr; CondSel = cs;
    n_c = m_c; n_n = m_n; n_e = m_e;
    new_err = 0; push_take = 0; pop_take = 0; top = '0;
    if (push && pop) new_err = 1;
    else if (push) begin
      if (m_stack.size() == DEPTH) new_err = 1; else push_take = 1;
    end else if (pop) begin
      if (m_stack.size() == 0) new_err = 1; else pop_take = 1;
    end
    if (pop_take) begin
      top = m_stack[$];
      {n_c, n_n, n_e} = top;
    end else if (we) begin
      if (sel == 4'd0) n_c = c;
      else if (sel == 4'd1) begin n_n = n; n_e = e; end
    end
    n_err = new_err ? 1'b1 : (clr ? 1'b0 : m_err);
    #1;
`ifdef ALU_FLAG_BYPASS_EN
    check("cond_true", 8'(CondTrue), 8'(cond_ref(cs, n_c, n_n, n_e)));
`else
    check("cond_true", 8'(CondTrue), 8'(cond_ref(cs, m_c, m_n, m_e)));
`endif
    @(posedge clk);
    if (push_take) m_stack.push_back({m_c, m_n, m_e});
    if (pop_take) void'(m_stack.pop_back());
    m_c = n_c; m_n = n_n; m_e = n_e; m_err = n_err;
  endtask

  task automatic idle(input logic [2:0] cs);
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 0, cs);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    check_regs();
    FlagWe = 1; Selector = 4'd0; CarryIn = 1; Push = 1; Pop = 0; ErrClr = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_regs();
    @(negedge clk);
    FlagWe = 0; Push = 0;
    rst_n = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    logic [3:0] sel;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) sel = 4'd0;
      else if (r == 1) sel = 4'd1;
      else if (r == 2) sel = 4'($urandom_range(0, 1));
      else sel = 4'($urandom_range(2, 15));
      cycle(1'($urandom_range(0, 1)), sel, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst_n = 1'b1;

    // Sub write sets Neg, then LT evaluates true.
    cycle(1, 4'd1, 0, 1, 0, 0, 0, 0, 3'd3);
    idle(3'd3);
    // Selective updates and an ignored non-arith write.
    cycle(1, 4'd0, 1, 0, 0, 0, 0, 0, 3'd5);
    cycle(1, 4'd1, 0, 0, 1, 0, 0, 0, 3'd1);
    cycle(1, 4'd5, 0, 1, 0, 0, 0, 0, 3'd4);
    idle(3'd6);
    // Overfill then overdrain, with flags changing between pushes.
    for (int i = 0; i < 5; i++)
      cycle(1, 4'(i % 2), 1'(i), 1'(i >> 1), 1'(~i), 1, 0, 0, 3'(i));
    idle(3'd0);
    for (int i = 0; i < 5; i++) cycle(0, 4'd0, 0, 0, 0, 0, 1, 0, 3'(i + 1));
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 1, 3'd7);
    // Push with write, then pop with write.
    mid_reset();
    cycle(1, 4'd0, 1, 0, 0, 1, 0, 0, 3'd5);
    cycle(1, 4'd0, 1, 0, 0, 0, 1, 0, 3'd5);
    idle(3'd5);
    // Push and pop together, then clear the error; clear against a new error.
    cycle(1, 4'd1, 0, 1, 1, 1, 1, 0, 3'd2);
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 1, 3'd0);
    cycle(0, 4'd0, 0, 0, 0, 0, 1, 1, 3'd0);
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 1, 3'd0);
    // Compare-and-branch in the same cycle.
    cycle(1, 4'd1, 0, 0, 1, 0, 0, 0, 3'd1);
    idle(3'd1);

    random_cycles(600);
    mid_reset();
    random_cycles(300);
    @(negedge clk);
    check_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
